// File: rtl/voter_pkg.sv
// -----------------------------------------------------------------------------
// voter_pkg
// Shared constants for the majority-voter vector loader.
//   VEC_W   : width of the voter input vector
//   WORD_W  : width of one streamed input word
//   NWORDS  : words per vector, ceil(VEC_W / WORD_W)
//   FCNT_W  : width of the accepted-frame counter
// -----------------------------------------------------------------------------
package voter_pkg;

  localparam int VEC_W  = 1001;
  localparam int WORD_W = 32;
  localparam int FCNT_W = 20;

  function automatic int calc_nwords(input int vec_w, input int word_w);
    return (vec_w + word_w - 1) / word_w;
  endfunction

  // Counter width that still works for a single-word vector.
  function automatic int calc_cnt_w(input int nwords);
    return (nwords > 1) ? $clog2(nwords) : 1;
  endfunction

  localparam int NWORDS = calc_nwords(VEC_W, WORD_W);

endpackage

// File: rtl/voter_vec_loader_if.sv
// -----------------------------------------------------------------------------
// voter_vec_loader_if
// Word-stream input and vector output handshakes of the loader.
//   s_valid/s_ready/s_data/s_last : input word stream, LSB word first
//   vec/vec_valid/vec_ready       : assembled vector toward the voter
// modport master : the producer/consumer environment
// modport slave  : the loader
// -----------------------------------------------------------------------------
interface voter_vec_loader_if #(
  parameter int VEC_W  = voter_pkg::VEC_W,
  parameter int WORD_W = voter_pkg::WORD_W
);
  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] s_data;
  logic              s_last;
  logic [VEC_W-1:0]  vec;
  logic              vec_valid;
  logic              vec_ready;

  modport master (
    output s_valid, s_data, s_last, vec_ready,
    input  s_ready, vec, vec_valid
  );

  modport slave (
    input  s_valid, s_data, s_last, vec_ready,
    output s_ready, vec, vec_valid
  );
endinterface

// File: rtl/voter_vec_asm.sv
// -----------------------------------------------------------------------------
// voter_vec_asm
// Assembly stage: word counter, assembly register and framing check.
//   clk, rst_n : clock, async active-low reset
//   wr         : an input word is transferred this cycle
//   data, last : the word and its end-of-frame marker
//   take       : the output stage is copying asm this cycle
//   clr_err    : synchronous clear of the sticky error
//   asm        : assembled vector (upper bits of the last word discarded)
//   asm_full   : asm holds a complete frame
//   err        : sticky framing error
// -----------------------------------------------------------------------------
module voter_vec_asm #(
  parameter int VEC_W  = voter_pkg::VEC_W,
  parameter int WORD_W = voter_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [WORD_W-1:0] data,
  input  logic              last,
  input  logic              take,
  input  logic              clr_err,
  output logic [VEC_W-1:0]  asm,
  output logic              asm_full,
  output logic              err
);
  import voter_pkg::*;

  localparam int NUM_WORDS = calc_nwords(VEC_W, WORD_W);
  localparam int CNT_W     = calc_cnt_w(NUM_WORDS);

  logic [CNT_W-1:0] wcnt;
  logic             last_slot;
  logic             wr_good;
  logic             wr_bad;
  logic [VEC_W-1:0] rep;
  logic [VEC_W-1:0] mask;

  assign last_slot = (wcnt == CNT_W'(NUM_WORDS - 1));
  // s_last must coincide exactly with the final slot; any disagreement is a framing error.
  assign wr_bad    = wr && (last != last_slot);
  assign wr_good   = wr && last && last_slot;

  // The word replicated across every slot, plus a mask selecting slot wcnt.
  // Truncating to VEC_W drops the unused top bits of the final word.
  assign rep  = VEC_W'({NUM_WORDS{data}});
  assign mask = VEC_W'({WORD_W{1'b1}}) << (32'(wcnt) * WORD_W);

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt     <= '0;
      asm_full <= 1'b0;
      err      <= 1'b0;
    end else begin
      // Both a completed frame and an error restart the count at slot 0.
      if (wr) wcnt <= (last_slot || last) ? '0 : wcnt + 1'b1;

      if (wr_good)   asm_full <= 1'b1;
      else if (take) asm_full <= 1'b0;

      // A new error takes priority over a simultaneous clear.
      if (wr_bad)       err <= 1'b1;
      else if (clr_err) err <= 1'b0;
    end
  end

  // NOTE: asm is wide data storage qualified by asm_full, so it carries no
  // reset; stale contents are never observed.
  always_ff @(posedge clk) begin
    if (wr && !wr_bad) asm <= (asm & ~mask) | (rep & mask);
  end

endmodule

// File: rtl/voter_vec_loader.sv
// -----------------------------------------------------------------------------
// voter_vec_loader
// Streams WORD_W-bit words into a VEC_W-bit majority-voter input vector.
// An assembly stage fills while the output register holds the previous frame.
//   clk, rst_n : clock, async active-low reset
//   bus        : word-stream input and vector output handshakes (slave)
//   clr_err    : synchronous clear of err
//   err        : sticky framing error
//   frame_cnt  : frames accepted at the vector output, wraps
// -----------------------------------------------------------------------------
module voter_vec_loader #(
  parameter int VEC_W  = voter_pkg::VEC_W,
  parameter int WORD_W = voter_pkg::WORD_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  voter_vec_loader_if.slave            bus,
  input  logic                         clr_err,
  output logic                         err,
  output logic [voter_pkg::FCNT_W-1:0] frame_cnt
);
  import voter_pkg::*;

  logic [VEC_W-1:0] asm;
  logic             asm_full;
  logic             take;
  logic             wr;
  logic             out_xfer;

  assign take     = asm_full && (!bus.vec_valid || bus.vec_ready);
  // A full asm still accepts the next word in the cycle it drains into vec,
  // which keeps the stream at one vector per NWORDS cycles.
  assign bus.s_ready = !asm_full || take;
  assign wr       = bus.s_valid && bus.s_ready;
  assign out_xfer = bus.vec_valid && bus.vec_ready;

  voter_vec_asm #(
    .VEC_W  (VEC_W),
    .WORD_W (WORD_W)
  ) u_asm (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr       (wr),
    .data     (bus.s_data),
    .last     (bus.s_last),
    .take     (take),
    .clr_err  (clr_err),
    .asm      (asm),
    .asm_full (asm_full),
    .err      (err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.vec       <= '0;
      bus.vec_valid <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      // vec only reloads on take, so it holds while the consumer stalls.
      if (take) begin
        bus.vec       <= asm;
        bus.vec_valid <= 1'b1;
      end else if (out_xfer) begin
        bus.vec_valid <= 1'b0;
      end

      if (out_xfer) frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_voter_vec_loader.sv
// -----------------------------------------------------------------------------
// tb_voter_vec_loader
// Directed self-checking bench for voter_vec_loader at default parameters.
// -----------------------------------------------------------------------------
module tb_voter_vec_loader;
  import voter_pkg::*;

  localparam int VW = VEC_W;
  localparam int WW = WORD_W;
  localparam int NW = NWORDS;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clr_err = 1'b0;
  logic              err;
  logic [FCNT_W-1:0] frame_cnt;

  voter_vec_loader_if #(.VEC_W(VW), .WORD_W(WW)) bus ();

  voter_vec_loader #(.VEC_W(VW), .WORD_W(WW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .clr_err   (clr_err),
    .err       (err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output-transfer monitor, sampled on the falling edge.
  logic            mon_en = 1'b0;
  int              xfer_cyc[$];
  logic [VW-1:0]   xfer_vec[$];
  always @(negedge clk) begin
    if (mon_en && bus.vec_valid && bus.vec_ready) begin
      xfer_cyc.push_back(cyc);
      xfer_vec.push_back(bus.vec);
    end
  end

  // Word k of a frame with a given seed; seed 0 gives word k = k.
  function automatic logic [WW-1:0] wval(input int seed, input int k);
    return WW'(k) ^ (WW'(seed) * WW'(32'h9E37_79B9));
  endfunction

  function automatic logic [VW-1:0] build(input int seed);
    logic [NW*WW-1:0] t;
    for (int k = 0; k < NW; k++) t[k*WW +: WW] = wval(seed, k);
    return t[VW-1:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    logic [NW*WW-1:0] a;
    logic [NW*WW-1:0] e;
    a = (NW*WW)'(obs);
    e = (NW*WW)'(exp);
    for (int k = 0; k < NW; k++)
      check($sformatf("%s.w%0d", tag, k), 64'(a[k*WW +: WW]), 64'(e[k*WW +: WW]));
  endtask

  task automatic send_word(input logic [WW-1:0] data, input logic last);
    int budget;
    budget = 0;
    bus.s_data  = data;
    bus.s_last  = last;
    bus.s_valid = 1'b1;
    while (!bus.s_ready && budget < 200) begin
      @(posedge clk);
      #1;
      budget++;
    end
    if (!bus.s_ready) begin
      n_cmp++;
      n_mis++;
      $error("FAIL send_timeout: observed s_ready=0 expected s_ready=1 within 200 cycles");
    end else begin
      @(posedge clk);
      #1;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic send_frame(input int seed, input int nwords, input int last_at);
    for (int k = 0; k < nwords; k++) send_word(wval(seed, k), k == last_at);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.s_valid   = 1'b0;
    bus.s_last    = 1'b0;
    bus.s_data    = '0;
    bus.vec_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready", 64'(bus.s_ready), 64'd1);
    check("rst_vec_valid", 64'(bus.vec_valid), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check_vec("rst_vec", bus.vec, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame: word k = k, latency and frame count
    bus.vec_ready = 1'b1;
    send_frame(0, NW, NW - 1);
    check("a_lat_n", 64'(bus.vec_valid), 64'd0);
    @(posedge clk); #1;
    check("a_lat_n1", 64'(bus.vec_valid), 64'd1);
    check_vec("a_vec", bus.vec, build(0));
    check("a_top", 64'(bus.vec[VW-1:(NW-1)*WW]), 64'd31);
    check("a_cnt0", 64'(frame_cnt), 64'd0);
    @(posedge clk); #1;
    check("a_valid_drop", 64'(bus.vec_valid), 64'd0);
    check("a_cnt1", 64'(frame_cnt), 64'd1);

    // Early s_last, missing s_last, clear, set-wins-over-clear
    do_reset();
    bus.vec_ready = 1'b1;
    send_frame(1, 11, 10);
    check("b_err_early", 64'(err), 64'd1);
    check("b_s_ready", 64'(bus.s_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("b_no_valid", 64'(bus.vec_valid), 64'd0);
    send_frame(2, NW, NW - 1);
    @(posedge clk); #1;
    check("b_valid", 64'(bus.vec_valid), 64'd1);
    check_vec("b_vec", bus.vec, build(2));
    @(posedge clk); #1;
    check("b_cnt1", 64'(frame_cnt), 64'd1);
    check("b_err_sticky", 64'(err), 64'd1);
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    check("b_err_clr", 64'(err), 64'd0);
    send_frame(3, NW, -1);
    check("b_err_nolast", 64'(err), 64'd1);
    @(posedge clk); #1;
    check("b_nolast_valid", 64'(bus.vec_valid), 64'd0);
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    check("b_err_clr2", 64'(err), 64'd0);
    send_frame(4, 5, -1);
    clr_err = 1'b1;
    send_word(wval(4, 5), 1'b1);
    clr_err = 1'b0;
    check("b_set_wins", 64'(err), 64'd1);
    send_frame(5, NW, NW - 1);
    @(posedge clk); #1;
    check_vec("b_vec_after", bus.vec, build(5));
    @(posedge clk); #1;
    check("b_cnt2", 64'(frame_cnt), 64'd2);

    // Back-pressure: two frames with vec_ready low
    do_reset();
    bus.vec_ready = 1'b0;
    send_frame(6, NW, NW - 1);
    send_frame(7, NW, NW - 1);
    check("c_s_ready_low", 64'(bus.s_ready), 64'd0);
    check("c_valid_held", 64'(bus.vec_valid), 64'd1);
    check_vec("c_vec_held", bus.vec, build(6));
    check("c_cnt0", 64'(frame_cnt), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check_vec("c_vec_stable", bus.vec, build(6));
    check("c_s_ready_still", 64'(bus.s_ready), 64'd0);
    bus.vec_ready = 1'b1;
    @(posedge clk); #1;
    check("c_valid2", 64'(bus.vec_valid), 64'd1);
    check_vec("c_vec2", bus.vec, build(7));
    check("c_cnt1", 64'(frame_cnt), 64'd1);
    @(posedge clk); #1;
    check("c_valid_drop", 64'(bus.vec_valid), 64'd0);
    check("c_cnt2", 64'(frame_cnt), 64'd2);

    // Continuous stream of 4 frames
    do_reset();
    bus.vec_ready = 1'b1;
    mon_en = 1'b1;
    for (int f = 0; f < 4; f++) send_frame(10 + f, NW, NW - 1);
    repeat (4) @(posedge clk);
    #1;
    mon_en = 1'b0;
    check("d_nxfer", 64'(xfer_vec.size()), 64'd4);
    for (int i = 0; i < xfer_vec.size(); i++)
      check_vec($sformatf("d_vec%0d", i), xfer_vec[i], build(10 + i));
    for (int i = 1; i < xfer_cyc.size(); i++)
      check($sformatf("d_gap%0d", i), 64'(xfer_cyc[i] - xfer_cyc[i-1]), 64'd32);
    check("d_cnt4", 64'(frame_cnt), 64'd4);

    // Reset mid-frame with a held vector
    do_reset();
    bus.vec_ready = 1'b0;
    send_frame(20, NW, NW - 1);
    send_frame(21, 16, -1);
    #2;
    rst_n = 1'b0;
    #1;
    check("e_valid", 64'(bus.vec_valid), 64'd0);
    check("e_s_ready", 64'(bus.s_ready), 64'd1);
    check("e_err", 64'(err), 64'd0);
    check("e_cnt", 64'(frame_cnt), 64'd0);
    check_vec("e_vec", bus.vec, '0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.vec_ready = 1'b1;
    send_frame(22, NW, NW - 1);
    @(posedge clk); #1;
    check("e_valid_new", 64'(bus.vec_valid), 64'd1);
    check_vec("e_vec_new", bus.vec, build(22));
    @(posedge clk); #1;
    check("e_cnt1", 64'(frame_cnt), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
